// File: rtl/mem_bridge.sv
// Core-to-wide-bus memory bridge: aligns byte/half/word accesses onto a strobed bus,
// tracks up to DEPTH in-order transactions and extends load data on the way back.
package mem_bridge_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_access_size_t;
endpackage

module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  mem_access_size_t       req_size,
  input  logic                   req_wr,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_wr,
  output logic [BUS_WIDTH-1:0]   mem_wdata,
  output logic [BUS_WIDTH/8-1:0] mem_wstrb,
  input  logic                   mem_rsp_valid,
  input  logic [BUS_WIDTH-1:0]   mem_rdata
);
  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(DEPTH);

  if (!(BUS_WIDTH == 32 || BUS_WIDTH == 64)) begin : g_bad_bus_width
    $error("mem_bridge: BUS_WIDTH must be 32 or 64");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_bridge: DEPTH must be a power of two in 2..16");
  end

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    mem_access_size_t  size;
    logic              uns;
    logic              wr;
  } entry_t;

  entry_t            fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [31:0]       rsp_rdata_reg;

  logic              aligned;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              mis_accept;
  logic [LANE_W-1:0] lane;
  logic [STRB_W-1:0] strb_base;
  entry_t            push_entry;
  entry_t            head;
  logic [31:0]       lane_word;
  logic [31:0]       load_data;
  logic [31:0]       rsp_rdata_next;

  // ---------------------------------------------------------------- request side
  always_comb begin
    aligned = 1'b0;
    case (req_size)
      BYTE:    aligned = 1'b1;
      HALF:    aligned = ~req_addr[0];
      WORD:    aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign lane  = req_addr[LANE_W-1:0];
  assign full  = (count_reg == COUNT_MAX);
  assign empty = (count_reg == '0);
  assign pop   = mem_rsp_valid & ~empty;

  // A misaligned request is answered locally, so it waits until nothing is in
  // flight and no memory response is about to occupy the response slot.
  assign req_ready     = aligned ? (mem_req_ready & ~full) : (empty & ~pop);
  assign mem_req_valid = req_valid & aligned & ~full;
  assign push          = mem_req_valid & mem_req_ready;
  assign mis_accept    = req_valid & ~aligned & empty & ~pop;

  assign mem_addr = {req_addr[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
  assign mem_wr   = req_wr;

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_wdata
    assign mem_wdata[8*gi +: 8] = (req_size == BYTE) ? req_wdata[7:0] :
                                  (req_size == HALF) ? req_wdata[8*(gi%2) +: 8] :
                                                       req_wdata[8*(gi%4) +: 8];
  end

  always_comb begin
    strb_base = '0;
    case (req_size)
      BYTE:    strb_base = STRB_W'(4'h1);
      HALF:    strb_base = STRB_W'(4'h3);
      WORD:    strb_base = STRB_W'(4'hF);
      default: strb_base = '0;
    endcase
    mem_wstrb = req_wr ? (strb_base << lane) : '0;
  end

  assign push_entry = '{lane: lane, size: req_size, uns: req_unsigned, wr: req_wr};

  // ---------------------------------------------------------------- tracking FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- response side
  assign head      = fifo_mem[rd_ptr_reg];
  assign lane_word = 32'(mem_rdata >> {head.lane, 3'b000});

  always_comb begin
    load_data = lane_word;
    case (head.size)
      BYTE:    load_data = {{24{~head.uns & lane_word[7]}}, lane_word[7:0]};
      HALF:    load_data = {{16{~head.uns & lane_word[15]}}, lane_word[15:0]};
      default: load_data = lane_word;
    endcase
  end

  assign rsp_rdata_next = (pop & ~head.wr) ? load_data : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 32'h0;
    end else begin
      rsp_valid_reg <= pop | mis_accept;
      rsp_err_reg   <= mis_accept;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then a randomized phase.
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_addr = 32'h0;
  mem_access_size_t req_size = BYTE;
  logic             req_wr = 1'b0;
  logic             req_unsigned = 1'b0;
  logic [31:0]      req_wdata = 32'h0;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             mem_req_valid;
  logic             mem_req_ready = 1'b0;
  logic [31:0]      mem_addr;
  logic             mem_wr;
  logic [63:0]      mem_wdata;
  logic [7:0]       mem_wstrb;
  logic             mem_rsp_valid = 1'b0;
  logic [63:0]      mem_rdata = 64'h0;

  mem_bridge #(.ADDR_WIDTH(32), .BUS_WIDTH(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_wr(req_wr), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    mem_access_size_t size;
    bit               wr;
    bit               uns;
    logic [31:0]      wdata;
  } req_t;

  req_t req_q[$];   // stimulus waiting to be accepted
  req_t mq[$];      // model: accepted, awaiting memory response

  int   checks = 0;
  int   failures = 0;
  bit   armed = 0;
  bit   acc_flag = 0;
  bit   e_valid = 0, e_err = 0;
  logic [31:0] e_rdata = 32'h0;

  // stimulus knobs
  int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
  bit          rsp_auto = 0;
  int          pulses = 0;
  bit          force_rd = 0;
  logic [63:0] rd_val = 64'h0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(mem_access_size_t s);
    return (s == BYTE) ? 1 : (s == HALF) ? 2 : 4;
  endfunction

  function automatic bit is_aligned(logic [31:0] a, mem_access_size_t s);
    if (s == BYTE) return 1'b1;
    if (s == HALF) return (a % 2) == 0;
    if (s == WORD) return (a % 4) == 0;
    return 1'b0;
  endfunction

  // Gather the addressed bytes, then widen with the sign or zeros.
  function automatic logic [31:0] exp_load(logic [63:0] d, int ln, int n, bit uns);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(ln+i) +: 8];
    if (!uns && n < 4 && v[8*n-1]) begin
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Compare process: registered outputs, request-side outputs, then model update.
  bit          x_ok, x_full, x_ready, x_mvalid, n_valid, n_err;
  logic [31:0] n_rdata;
  logic [7:0]  exp_strb;
  logic [63:0] exp_wd;
  req_t        head, acc;
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("rsp_valid", rsp_valid, e_valid);
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_rdata", rsp_rdata, e_rdata);
    end
    acc_flag = 0;
    if (reset) begin
      mq.delete();
      e_valid = 0; e_err = 0; e_rdata = 32'h0;
    end else begin
      x_ok     = is_aligned(req_addr, req_size);
      x_full   = (mq.size() == DEPTH);
      x_ready  = x_ok ? (mem_req_ready && !x_full) : (mq.size() == 0);
      x_mvalid = req_valid && x_ok && !x_full;
      if (armed) begin
        chk("req_ready", req_ready, x_ready);
        chk("mem_req_valid", mem_req_valid, x_mvalid);
        if (x_mvalid) begin
          exp_strb = 8'h0;
          for (int i = 0; i < nbytes(req_size); i++) exp_strb[(req_addr % 8) + i] = 1'b1;
          for (int p = 0; p < 8; p++) exp_wd[8*p +: 8] = req_wdata[8*(p % nbytes(req_size)) +: 8];
          chk("mem_addr", mem_addr, req_addr & ~32'h7);
          chk("mem_wr", mem_wr, req_wr);
          chk("mem_wstrb", mem_wstrb, req_wr ? exp_strb : 8'h0);
          if (req_wr) chk("mem_wdata", mem_wdata, exp_wd);
        end
      end
      n_valid = 0; n_err = 0; n_rdata = 32'h0;
      if (mem_rsp_valid && mq.size() > 0) begin
        head = mq.pop_front();
        n_valid = 1;
        n_rdata = head.wr ? 32'h0 : exp_load(mem_rdata, head.addr % 8, nbytes(head.size), head.uns);
      end
      if (req_valid && x_ready) begin
        acc_flag = 1;
        acc.addr = req_addr; acc.size = req_size; acc.wr = req_wr;
        acc.uns = req_unsigned; acc.wdata = req_wdata;
        if (x_ok) mq.push_back(acc);
        else begin n_valid = 1; n_err = 1; n_rdata = 32'h0; end
      end
      e_valid = n_valid; e_err = n_err; e_rdata = n_rdata;
    end
  end

  task automatic q_req(logic [31:0] a, mem_access_size_t s, bit wr, bit uns, logic [31:0] wd);
    req_t r;
    r.addr = a; r.size = s; r.wr = wr; r.uns = uns; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (req_valid && acc_flag) void'(req_q.pop_front());
    if (req_q.size() > 0) begin
      req_valid = 1'b1; req_addr = req_q[0].addr; req_size = req_q[0].size;
      req_wr = req_q[0].wr; req_unsigned = req_q[0].uns; req_wdata = req_q[0].wdata;
    end else begin
      req_valid = 1'b0;
    end
    case (rdy_mode)
      0:       mem_req_ready = ($urandom_range(0, 3) != 0);
      1:       mem_req_ready = 1'b1;
      default: mem_req_ready = 1'b0;
    endcase
    if (pulses > 0) begin
      mem_rsp_valid = 1'b1; pulses--;
    end else begin
      mem_rsp_valid = rsp_auto && ($urandom_range(0, 2) == 0);
    end
    mem_rdata = force_rd ? rd_val : {$urandom(), $urandom()};
  endtask

  task automatic expect_rsp(string name, logic [31:0] v, bit err);
    int n = 0;
    do begin step(); n++; end while (rsp_valid !== 1'b1 && n < 20);
    if (rsp_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s: rsp_valid never rose, expected rdata %h", name, v);
    end else begin
      chk({name, "_rdata"}, rsp_rdata, v);
      chk({name, "_err"}, rsp_err, err);
      chk({name, "_model"}, e_rdata, v);
    end
  endtask

  task automatic drain();
    int n = 0;
    rsp_auto = 1;
    while ((req_q.size() > 0 || mq.size() > 0 || rsp_valid) && n < 5000) begin step(); n++; end
    chk("drain_done", n < 5000, 1);
    pulses = 0; rsp_auto = 0; step();
  endtask

  mem_access_size_t rs;
  logic [31:0]      ra;
  int               pn;
  initial begin
    step(); step();
    reset = 1'b0; armed = 1;
    step(); #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);

    // read lanes
    rdy_mode = 1; force_rd = 1; rd_val = 64'h0000_80FF_0000_0000;
    q_req(32'h1005, BYTE, 0, 0, 32'h0);
    step(); #1;
    chk("t1_mem_addr", mem_addr, 32'h1000);
    chk("t1_wstrb", mem_wstrb, 8'h00);
    chk("t1_mvalid", mem_req_valid, 1);
    step(); pulses = 1;
    expect_rsp("t1_signed", 32'hFFFF_FF80, 0);
    q_req(32'h1005, BYTE, 0, 1, 32'h0);
    step(); step(); pulses = 1;
    expect_rsp("t1_unsigned", 32'h0000_0080, 0);
    force_rd = 0;

    // store strobes
    q_req(32'h2006, HALF, 1, 0, 32'h0000_BEEF);
    step(); #1;
    chk("t2_mem_addr", mem_addr, 32'h2000);
    chk("t2_half_strb", mem_wstrb, 8'hC0);
    chk("t2_half_wdata", mem_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    step();
    q_req(32'h2004, WORD, 1, 0, 32'hCAFE_F00D);
    step(); #1;
    chk("t2_word_strb", mem_wstrb, 8'hF0);
    chk("t2_word_wdata", mem_wdata, 64'hCAFE_F00D_CAFE_F00D);
    pulses = 2;
    expect_rsp("t2_store", 32'h0, 0);
    drain();

    // full FIFO backpressure
    for (int i = 0; i < 5; i++) q_req(32'h5000 + 32'(i * 3), BYTE, 0, 0, 32'h0);
    repeat (5) step();
    #1;
    chk("t3_full_ready", req_ready, 0);
    chk("t3_full_mvalid", mem_req_valid, 0);
    chk("t3_model_count", mq.size(), 4);
    step(); #1;
    chk("t3_still_full", req_ready, 0);
    pulses = 1;
    step(); #1;
    chk("t3_no_bypass", req_ready, 0);
    step(); #1;
    chk("t3_after_pop", req_ready, 1);
    pulses = 5;
    drain();

    // misaligned with two outstanding
    q_req(32'h3100, WORD, 0, 0, 32'h0);
    q_req(32'h3106, HALF, 0, 1, 32'h0);
    q_req(32'h3002, WORD, 0, 0, 32'h0);
    step(); step(); step(); #1;
    chk("t4_stall_ready", req_ready, 0);
    chk("t4_no_mreq", mem_req_valid, 0);
    pulses = 2;
    step(); #1; chk("t4_stall_a", req_ready, 0);
    step(); #1; chk("t4_stall_b", req_ready, 0);
    step(); #1;
    chk("t4_accept", req_ready, 1);
    chk("t4_accept_mvalid", mem_req_valid, 0);
    expect_rsp("t4_err", 32'h0, 1);
    drain();

    // streaming push/pop at count 2 with pointer wrap
    for (int i = 0; i < 20; i++) begin
      rs = mem_access_size_t'(i % 3);
      q_req(32'h6000 + 32'(i * 8) + 32'((i * 2) % (8 / nbytes(rs)) * nbytes(rs)), rs, 0, i[0], 32'h0);
    end
    step(); step();
    pulses = 20;
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      if (i == 5) begin
        chk("t5_model_count", mq.size(), 2);
        chk("t5_ready", req_ready, 1);
      end
    end
    drain();

    // reset with outstanding transactions, then stray responses
    for (int i = 0; i < 3; i++) q_req(32'h7000 + 32'(i), BYTE, 0, 0, 32'h0);
    repeat (4) step();
    reset = 1'b1; step(); reset = 1'b0;
    step(); #1;
    chk("t6_after_reset", rsp_valid, 0);
    pulses = 3;
    for (int i = 0; i < 4; i++) begin step(); #1; chk("t6_stray", rsp_valid, 0); end
    force_rd = 1; rd_val = 64'h1234_5678_9ABC_DEF0;
    q_req(32'h4004, WORD, 0, 0, 32'h0);
    step(); step(); pulses = 1;
    expect_rsp("t6_new_load", 32'h1234_5678, 0);
    force_rd = 0;
    drain();

    // randomized traffic
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      rs = mem_access_size_t'($urandom_range(0, 2));
      ra = $urandom() & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) ra = ra & ~32'(nbytes(rs) - 1);
      q_req(ra, rs, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom());
    end
    rsp_auto = 1;
    pn = 0;
    while (req_q.size() > 0 && pn < 20000) begin step(); pn++; end
    chk("rand_progress", pn < 20000, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Parametrised successor to the core's flat memory port. Converts byte/half/word core accesses into aligned, handshaked transactions on a wide memory bus with byte strobes.
- Supports up to DEPTH outstanding transactions, returned in order.
- Performs read-lane extraction with sign or zero extension, and detects misaligned accesses.
- Sits between the core load/store unit and the memory/cache.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- BUS_WIDTH, 64, memory data width in bits; legal values 32 or 64.
- DEPTH, 4, maximum outstanding transactions; power of two, 2..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  core request accepted when req_valid and req_ready are both high.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  mem_access_size_t  BYTE, HALF or WORD.
- req_wr  in  1  1 = store, 0 = load.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse; core cannot stall it.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_WIDTH  req_addr with the low log2(BUS_WIDTH/8) bits cleared.
- mem_wr  out  1  store.
- mem_wdata  out  BUS_WIDTH  store data.
- mem_wstrb  out  BUS_WIDTH/8  byte enables; 0 on reads.
- mem_rsp_valid  in  1  memory completion, in order, one per issued request (reads and writes).
- mem_rdata  in  BUS_WIDTH  read data, valid with mem_rsp_valid.

Behaviour:
- **Reset:** clears the tracking FIFO (count = 0) and drives rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- **Alignment:**
  - Aligned means: BYTE always; HALF when addr[0] = 0; WORD when addr[1:0] = 0.
  - A WORD access never crosses a 64-bit lane boundary, since it is aligned.
- **Aligned request issue** (combinational pass-through, no added latency):
  - mem_req_valid = req_valid & aligned & !full.
  - req_ready = mem_req_ready & !full.
  - On the handshake, push {lane = addr[L-1:0], size, unsigned, wr} into the FIFO, where L = log2(BUS_WIDTH/8).
- **Write data and strobes:**
  - mem_wdata = req_wdata replicated across the bus (byte replicated for BYTE, halfword for HALF, word for WORD).
  - mem_wstrb = (BYTE: 1, HALF: 3, WORD: 'hF) << lane.
- **Misaligned request:**
  - mem_req_valid stays 0.
  - req_ready = (count == 0) & !rsp_valid_next. Stall until all outstanding transactions drain.
  - On accept, the next cycle drives rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - No memory access is made and the FIFO is untouched.
- **Memory response:**
  - mem_rsp_valid with count > 0 pops the head entry.
  - The next cycle drives rsp_valid = 1 and rsp_err = 0.
  - rsp_rdata = 0 if wr. Otherwise rsp_rdata = extend(mem_rdata >> (lane*8), size, unsigned):
    - BYTE extends from bit 7.
    - HALF extends from bit 15.
    - WORD is passed through.
- **Latency:** mem_rsp_valid to rsp_valid is exactly 1 cycle.
- **Stray responses:** mem_rsp_valid with count == 0 is ignored. This covers responses to transactions discarded by a mid-operation reset. No response is produced.
- **FIFO boundaries:**
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - When full (count == DEPTH), req_ready = 0 even if a pop occurs the same cycle. There is no full-bypass.
  - Pointers wrap modulo DEPTH.
- **Response rate:** at most one rsp_valid per cycle. A misaligned response cannot collide with a memory response because of the drain rule.
- **Illegal configuration:** any BUS_WIDTH other than 32 or 64 is a compile-time error via an elaboration assertion.
- **Stable inputs:** req_* must be held while req_valid & !req_ready. The bridge does not register requests.

Test Plan:
1. **Read lanes, BUS_WIDTH=64.**
   - Load BYTE signed at 0x1005, mem_rdata = 0x0000_80FF_0000_0000 → mem_addr = 0x1000, mem_wstrb = 0, rsp_rdata = 0xFFFF_FF80 one cycle after mem_rsp_valid.
   - Same access with unsigned → 0x0000_0080.
2. **Store strobes.**
   - Store HALF 0xBEEF at 0x2006 → mem_addr = 0x2000, mem_wstrb = 0xC0, mem_wdata = 0xBEEF_BEEF_BEEF_BEEF.
   - Store WORD at 0x2004 → mem_wstrb = 0xF0.
3. **Backpressure and full FIFO, DEPTH=4, no mem_rsp.**
   - Issue 4 loads → 5th request sees req_ready = 0.
   - One mem_rsp_valid → 5th request accepted in the cycle after the pop.
   - 5 responses return in issue order with correct per-entry lanes.
4. **Misaligned access.**
   - WORD load at 0x3002 with 2 outstanding → req_ready = 0 until both responses emitted.
   - Then accepted → rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, and no mem_req_valid pulse.
5. **Simultaneous push/pop and wrap.**
   - Stream 20 loads with mem_rsp_valid every cycle at count = 2 → count stays 2, pointers wrap, 20 in-order responses with correct data.
6. **Reset mid-operation.**
   - Assert reset with 3 outstanding → FIFO empty and rsp_valid = 0 after reset.
   - 3 subsequent stray mem_rsp_valid pulses produce no rsp_valid.
   - A new load completes normally.
